// File: rtl/mac_acc_pkg.sv
// Shared definitions for the product accumulator: state encoding, width
// defaults and block sizing.
package mac_acc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } state_t;

   localparam int PROD_W_DEF = 64;
   localparam int ACC_W_DEF  = 72;
   localparam int BLOCK_MAX  = 64;

   // A block_len of zero encodes a full block of BLOCK_MAX products.
   function automatic logic [6:0] target_of(input logic [5:0] len);
      return (len == 6'd0) ? 7'(BLOCK_MAX) : {1'b0, len};
   endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums a block of unsigned products from an upstream multiplier and presents
// the final sum with a valid/ready handshake.
module product_accumulator
   import mac_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [5:0]        block_len,
   input  logic              abort,
   input  logic              prod_valid,
   input  logic [PROD_W-1:0] product,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  sum,
   output logic              sum_valid,
   input  logic              sum_ready,
   output logic              busy,
   output logic [6:0]        count
);

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc;
   logic [6:0]       cnt;
   logic [6:0]       target;
   logic             xfer;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      prod_ready = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = ACCUM;
         end
         ACCUM: begin
            prod_ready = !abort;
            if (abort) begin
               state_nxt = IDLE;
            end else if (prod_valid && (cnt + 7'd1 == target)) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (sum_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign xfer = prod_valid && prod_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc    <= '0;
         cnt    <= '0;
         target <= 7'(BLOCK_MAX);
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc    <= '0;
                  cnt    <= '0;
                  target <= target_of(block_len);
               end
            end
            ACCUM: begin
               if (abort) begin
                  acc <= '0;
                  cnt <= '0;
               end else if (xfer) begin
                  acc <= acc + ACC_W'(product);
                  cnt <= cnt + 7'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum       = acc;
   assign count     = cnt;
   assign sum_valid = (state == HOLD);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator with a block-level reference model
// checked every cycle plus literal expectations at key points.
module tb_product_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  block_len = '0;
   logic        abort = 1'b0;
   logic        prod_valid = 1'b0;
   logic [63:0] product = '0;
   logic        prod_ready;
   logic [71:0] sum;
   logic        sum_valid;
   logic        sum_ready = 1'b0;
   logic        busy;
   logic [6:0]  count;

   int checks = 0;
   int failures = 0;

   // Reference model: block membership, the running total and the number of
   // accepted products, tracked directly from the block-level rules.
   bit          m_in_block = 1'b0;
   bit          m_holding = 1'b0;
   logic [71:0] m_sum = '0;
   int          m_cnt = 0;
   int          m_tgt = 64;

   product_accumulator #(.PROD_W(64), .ACC_W(72)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .block_len  (block_len),
      .abort      (abort),
      .prod_valid (prod_valid),
      .product    (product),
      .prod_ready (prod_ready),
      .sum        (sum),
      .sum_valid  (sum_valid),
      .sum_ready  (sum_ready),
      .busy       (busy),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_in_block = 1'b0;
         m_holding  = 1'b0;
         m_sum      = '0;
         m_cnt      = 0;
         m_tgt      = 64;
      end else if (!m_in_block) begin
         if (start) begin
            m_in_block = 1'b1;
            m_holding  = 1'b0;
            m_sum      = '0;
            m_cnt      = 0;
            m_tgt      = (block_len == 0) ? 64 : int'(block_len);
         end
      end else if (m_holding) begin
         if (sum_ready) begin
            m_in_block = 1'b0;
            m_holding  = 1'b0;
         end
      end else if (abort) begin
         m_in_block = 1'b0;
         m_sum      = '0;
         m_cnt      = 0;
      end else if (prod_valid) begin
         m_sum = m_sum + {8'd0, product};
         m_cnt = m_cnt + 1;
         if (m_cnt == m_tgt) m_holding = 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("prod_ready", {71'd0, prod_ready}, {71'd0, m_in_block && !m_holding && !abort});
      chk("busy",       {71'd0, busy},       {71'd0, m_in_block});
      chk("sum_valid",  {71'd0, sum_valid},  {71'd0, m_holding});
      chk("sum",        sum,                 m_sum);
      chk("count",      {65'd0, count},      72'(m_cnt));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_block(input logic [5:0] len);
      start     = 1'b1;
      block_len = len;
      tick();
      start     = 1'b0;
   endtask

   task automatic push(input logic [63:0] p);
      prod_valid = 1'b1;
      product    = p;
      tick();
      prod_valid = 1'b0;
   endtask

   task automatic release_sum();
      sum_ready = 1'b1;
      tick();
      sum_ready = 1'b0;
   endtask

   initial begin
      #3 rst = 1'b0;
      #1;
      chk("reset_busy",       {71'd0, busy},       72'd0);
      chk("reset_prod_ready", {71'd0, prod_ready}, 72'd0);
      chk("reset_sum_valid",  {71'd0, sum_valid},  72'd0);
      chk("reset_count",      {65'd0, count},      72'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Three back-to-back products.
      begin_block(6'd3);
      push(64'd5);
      push(64'd7);
      push(64'd11);
      chk("b3_sum_valid", {71'd0, sum_valid}, 72'd1);
      chk("b3_sum",       sum,                72'd23);
      chk("b3_count",     {65'd0, count},     72'd3);
      release_sum();
      chk("b3_idle",      {71'd0, busy},      72'd0);
      chk("b3_sum_kept",  sum,                72'd23);

      // Full 64-product block of all-ones: largest possible sum.
      begin_block(6'd0);
      for (int i = 0; i < 64; i++) push('1);
      chk("b64_sum",   sum,            72'h3F_FFFF_FFFF_FFFF_FFC0);
      chk("b64_count", {65'd0, count}, 72'd64);
      release_sum();

      // Gaps between products and a stalled consumer.
      begin_block(6'd2);
      push(64'd9);
      repeat (3) tick();
      push(64'd9);
      chk("gap_sum", sum, 72'd18);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_sum_valid", {71'd0, sum_valid}, 72'd1);
         chk("stall_sum",       sum,                72'd18);
      end
      release_sum();
      chk("stall_idle",      {71'd0, busy},      72'd0);
      chk("stall_valid_low", {71'd0, sum_valid}, 72'd0);

      // Abort with a product on offer.
      begin_block(6'd4);
      push(64'd1);
      push(64'd2);
      prod_valid = 1'b1;
      product    = 64'd100;
      abort      = 1'b1;
      #1;
      chk("abort_ready_low", {71'd0, prod_ready}, 72'd0);
      tick();
      prod_valid = 1'b0;
      abort      = 1'b0;
      chk("abort_idle",  {71'd0, busy},  72'd0);
      chk("abort_sum",   sum,            72'd0);
      chk("abort_count", {65'd0, count}, 72'd0);
      tick();

      // Reset between edges in the middle of a block.
      begin_block(6'd3);
      push(64'd8);
      #2 rst = 1'b0;
      #1;
      chk("midrst_busy",  {71'd0, busy},      72'd0);
      chk("midrst_count", {65'd0, count},     72'd0);
      chk("midrst_valid", {71'd0, sum_valid}, 72'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      tick();
      begin_block(6'd1);
      push(64'd42);
      chk("post_rst_sum", sum, 72'd42);
      release_sum();

      // Start pulses in ACCUM and in the releasing HOLD cycle are ignored.
      begin_block(6'd2);
      start      = 1'b1;
      block_len  = 6'd5;
      push(64'd3);
      start      = 1'b0;
      push(64'd4);
      chk("ign_sum_valid", {71'd0, sum_valid}, 72'd1);
      chk("ign_sum",       sum,                72'd7);
      start     = 1'b1;
      block_len = 6'd7;
      release_sum();
      start     = 1'b0;
      chk("ign_hold_start", {71'd0, busy}, 72'd0);
      tick();

      // Start beats abort in IDLE.
      start     = 1'b1;
      abort     = 1'b1;
      block_len = 6'd1;
      tick();
      start     = 1'b0;
      abort     = 1'b0;
      chk("start_wins", {71'd0, busy}, 72'd1);
      push(64'd6);
      chk("start_wins_sum", sum, 72'd6);
      release_sum();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter PROD_W, default 64, SHALL set the width of the incoming product.
REQ-002 Parameter ACC_W, default 72, SHALL set the accumulator width and SHALL be at least PROD_W+7.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 start  input  1  SHALL be a one-cycle pulse that opens a new accumulation block; it is honoured only in IDLE.
REQ-006 block_len  input  6  SHALL give the number of products per block, sampled with start; 0 means 64.
REQ-007 abort  input  1  SHALL cancel the current block.
REQ-008 prod_valid  input  1  SHALL indicate that product is valid.
REQ-009 product  input  PROD_W  SHALL carry the unsigned product from the upstream multiplier.
REQ-010 prod_ready  output  1  SHALL indicate that the block accepts a product this cycle.
REQ-011 sum  output  ACC_W  SHALL carry the accumulated unsigned sum.
REQ-012 sum_valid  output  1  SHALL indicate that sum is final and stable.
REQ-013 sum_ready  input  1  SHALL indicate that the downstream stage consumes sum.
REQ-014 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-015 count  output  7  SHALL give the number of products accepted in the current block.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-017 IDLE: start=1 SHALL clear the accumulator and count, latch target=(block_len==0 ? 64 : block_len), and move to ACCUM on the next edge.
REQ-018 prod_ready SHALL equal (state==ACCUM) && !abort, combinationally.
REQ-019 A transfer SHALL occur only when prod_valid && prod_ready; then acc <= acc + zero-extended product and count <= count+1.
REQ-020 When the transfer makes count equal target, the FSM SHALL enter HOLD; sum_valid SHALL be high in the next cycle, and sum SHALL include that last product (latency of 1 cycle after the final transfer).
REQ-021 Cycles with prod_valid=0 in ACCUM SHALL leave acc, count and state unchanged, with no timeout.
REQ-022 HOLD: sum_valid=1 and sum SHALL stay stable until sum_ready=1; that edge SHALL return the FSM to IDLE with sum_valid low.
REQ-023 sum SHALL hold its last value in IDLE and SHALL equal acc at all times.
REQ-024 The accumulator SHALL never overflow: 64 × (2^64−1) < 2^72. No saturation logic is required.
REQ-025 abort in ACCUM SHALL return the FSM to IDLE, clear acc and count, and discard any product presented that cycle; sum_valid SHALL not assert.
REQ-026 abort SHALL be ignored in IDLE and HOLD.
REQ-027 start SHALL be ignored outside IDLE, including in the HOLD cycle where sum_ready=1; a new block needs start in a later IDLE cycle.
REQ-028 When start and abort are both high in IDLE, start SHALL win.
REQ-029 An upstream stage that holds prod_valid high with a stable product while prod_ready is low SHALL lose no data.

Reset
REQ-030 While rst=0, asynchronously: state=IDLE, acc=0, count=0, target=64, sum_valid=0, prod_ready=0, busy=0.
REQ-031 Reset asserted mid-block SHALL discard the partial sum with no output handshake.
REQ-032 Deassertion SHALL be synchronised externally; the first active edge after deassertion SHALL see IDLE.

Structure
REQ-033 A shared package mac_acc_pkg SHALL hold the state enum (IDLE, ACCUM, HOLD), the PROD_W/ACC_W defaults and the BLOCK_MAX=64 constant.
REQ-034 The block SHALL be a single module; the adder and the counter are inline and no sub-module is warranted.

Verification
REQ-035 Reset, then start with block_len=3 and products 5, 7, 11 back-to-back -> sum_valid 1 cycle after the third transfer, sum=23, count=3.
REQ-036 start with block_len=0 and 64 products of 0xFFFF_FFFF_FFFF_FFFF -> sum=0x3F_FFFF_FFFF_FFFF_FFC0, count=64, no wrap.
REQ-037 block_len=2, product=9 with prod_valid gaps of 3 idle cycles, sum_ready held low 5 cycles -> sum=18 stable and sum_valid high throughout; IDLE the edge after sum_ready=1.
REQ-038 block_len=4, abort after 2 transfers while prod_valid=1 with product 100 -> prod_ready=0 that cycle, product not added, IDLE, sum_valid never high.
REQ-039 rst driven low mid-block after 1 of 3 transfers, between clock edges -> immediate IDLE, count=0, busy=0; a subsequent start with block_len=1 and product 42 -> sum=42.
REQ-040 start pulsed during ACCUM and during HOLD -> ignored; target and acc unaffected.
